// File: rtl/clause_pkg.sv
// clause_pkg: shared clause geometry, clause type and receive-queue state encoding
package clause_pkg;

    localparam int CLA_LENGTH      = 3;
    localparam int VARIABLE_LENGTH = 11;
    localparam int CLAUSE_W        = CLA_LENGTH * VARIABLE_LENGTH;
    localparam int LIT_IDX_MAX     = (1 << (VARIABLE_LENGTH - 1)) - 1;
    localparam int NUM_ENGINE      = 4;

    typedef logic [CLAUSE_W-1:0] clause_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/clause_rx_storage.sv
// clause_rx_storage: circular clause buffer with read/write pointers and occupancy count
module clause_rx_storage #(
    parameter int DEPTH = 8,
    parameter int W     = clause_pkg::CLAUSE_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;

    // occupancy moves only when exactly one of push/pop happens
    always_comb begin
        count_d = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    end

    // payload array is never reset; the top gates the head with valid
    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q] <= din;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign dout  = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/clause_rx_queue.sv
// clause_rx_queue: per-engine clause receive queue with flush FSM, early full and sticky overflow; CLAUSE_RX_BYPASS_EN enables empty-queue bypass
module clause_rx_queue #(
    parameter int DEPTH           = 8,
    parameter int CLA_LENGTH      = clause_pkg::CLA_LENGTH,
    parameter int VARIABLE_LENGTH = clause_pkg::VARIABLE_LENGTH
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  grant_in,
    input  logic [CLA_LENGTH*VARIABLE_LENGTH-1:0] clause_in,
    input  logic                                  flush_in,
    input  logic                                  clause_ready_in,
    output logic                                  full_out,
    output logic                                  start_out,
    output logic [CLA_LENGTH*VARIABLE_LENGTH-1:0] clause_out,
    output logic                                  clause_valid_out,
    output logic [$clog2(DEPTH):0]                count_out,
    output logic                                  overflow_err_out
);
    import clause_pkg::*;

    localparam int          W       = CLA_LENGTH * VARIABLE_LENGTH;
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] LIMIT   = (AW + 1)'(DEPTH);
    localparam logic [AW:0] EARLY_F = (AW + 1)'(DEPTH - 1);

    state_e       state_q;
    state_e       state_d;
    logic         fl_cnt_q;
    logic         fl_cnt_d;
    logic         err_q;
    logic [W-1:0] head;
    logic [AW:0]  count;
    logic         run;
    logic         live;
    logic         empty;
    logic         at_limit;
    logic         byp;
    logic         pop_st;
    logic         push;
    logic         ovf;

    assign run      = state_q == RUN;
    assign live     = run && !flush_in;
    assign empty    = count == '0;
    assign at_limit = count == LIMIT;

`ifdef CLAUSE_RX_BYPASS_EN
    assign byp = live && empty && grant_in;
`else
    assign byp = 1'b0;
`endif

    assign pop_st = live && !empty && clause_ready_in;
    assign push   = live && grant_in && (!at_limit || pop_st) && !(byp && clause_ready_in);
    assign ovf    = live && grant_in && at_limit && !pop_st;

    clause_rx_storage #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_storage (
        .clock (clock),
        .reset (reset),
        .clear (run && flush_in),
        .push  (push),
        .pop   (pop_st),
        .din   (clause_in),
        .dout  (head),
        .count (count)
    );

    // INIT always falls into RUN; FLUSH needs two quiet cycles before RUN
    always_comb begin
        state_d  = state_q == RUN ? (flush_in ? FLUSH : RUN) : state_q == FLUSH ? ((!flush_in && fl_cnt_q) ? RUN : FLUSH) : RUN;
        fl_cnt_d = state_q == FLUSH && !flush_in;
    end

    // state, flush timer and sticky overflow flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= INIT;
            fl_cnt_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fl_cnt_q <= fl_cnt_d;
            if (ovf) err_q <= 1'b1;
        end
    end

    assign full_out         = !run || count >= EARLY_F;
    assign start_out        = run;
    assign clause_valid_out = run && (!empty || byp);
    assign clause_out       = (run && !empty) ? head : byp ? clause_in : '0;
    assign count_out        = count;
    assign overflow_err_out = err_q;

endmodule

// File: tb/tb_clause_rx_queue.sv
// tb_clause_rx_queue: directed self-checking bench for clause_rx_queue (DEPTH=8); honours CLAUSE_RX_BYPASS_EN
module tb_clause_rx_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        grant_in = 1'b0;
    logic [32:0] clause_in = '0;
    logic        flush_in = 1'b0;
    logic        clause_ready_in = 1'b0;
    logic        full_out;
    logic        start_out;
    logic [32:0] clause_out;
    logic        clause_valid_out;
    logic [3:0]  count_out;
    logic        overflow_err_out;

    int checks = 0;
    int errors = 0;

    clause_rx_queue #(.DEPTH(8), .CLA_LENGTH(3), .VARIABLE_LENGTH(11)) dut (
        .clock            (clock),
        .reset            (reset),
        .grant_in         (grant_in),
        .clause_in        (clause_in),
        .flush_in         (flush_in),
        .clause_ready_in  (clause_ready_in),
        .full_out         (full_out),
        .start_out        (start_out),
        .clause_out       (clause_out),
        .clause_valid_out (clause_valid_out),
        .count_out        (count_out),
        .overflow_err_out (overflow_err_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tick;
        tick;
        chk("rst_count", count_out, 0);
        chk("rst_full", full_out, 1);
        chk("rst_start", start_out, 0);
        chk("rst_valid", clause_valid_out, 0);
        chk("rst_clause", clause_out, 0);
        chk("rst_err", overflow_err_out, 0);
        reset = 1'b1;
        #2;
        chk("init_full", full_out, 1);
        chk("init_start", start_out, 0);
        tick;
        #1;
        chk("run_start", start_out, 1);
        chk("run_full", full_out, 0);
        chk("run_count", count_out, 0);

        for (int i = 0; i < 8; i++) begin
            grant_in  = 1'b1;
            clause_in = 33'h100 + 33'(i);
            tick;
            #1;
            chk("fill_count", count_out, 64'(i + 1));
            chk("fill_full", full_out, (i >= 6) ? 64'd1 : 64'd0);
        end
        grant_in = 1'b0;
        #1;
        chk("fill_err", overflow_err_out, 0);
        chk("fill_valid", clause_valid_out, 1);
        chk("fill_head", clause_out, 33'h100);

        grant_in        = 1'b1;
        clause_in       = 33'h1AA;
        clause_ready_in = 1'b1;
        #1;
        chk("pp_head", clause_out, 33'h100);
        tick;
        grant_in        = 1'b0;
        clause_ready_in = 1'b0;
        #1;
        chk("pp_count", count_out, 8);
        chk("pp_err", overflow_err_out, 0);
        chk("pp_head_next", clause_out, 33'h101);

        grant_in  = 1'b1;
        clause_in = 33'h1BB;
        tick;
        grant_in = 1'b0;
        #1;
        chk("ovf_count", count_out, 8);
        chk("ovf_err", overflow_err_out, 1);
        tick;
        chk("ovf_err_held", overflow_err_out, 1);

        clause_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain_head", clause_out, (i < 7) ? 64'h101 + 64'(i) : 64'h1AA);
            tick;
        end
        clause_ready_in = 1'b0;
        #1;
        chk("drain_count", count_out, 0);
        chk("drain_valid", clause_valid_out, 0);
        chk("drain_err", overflow_err_out, 1);
        clause_ready_in = 1'b1;
        tick;
        clause_ready_in = 1'b0;
        #1;
        chk("empty_pop_count", count_out, 0);

        for (int i = 0; i < 5; i++) begin
            grant_in  = 1'b1;
            clause_in = 33'h200 + 33'(i);
            tick;
        end
        grant_in = 1'b0;
        #1;
        chk("pre_flush_count", count_out, 5);
        flush_in        = 1'b1;
        grant_in        = 1'b1;
        clause_ready_in = 1'b1;
        tick;
        flush_in        = 1'b0;
        clause_ready_in = 1'b0;
        #1;
        chk("fl1_count", count_out, 0);
        chk("fl1_full", full_out, 1);
        chk("fl1_start", start_out, 0);
        chk("fl1_valid", clause_valid_out, 0);
        chk("fl1_clause", clause_out, 0);
        tick;
        grant_in = 1'b0;
        #1;
        chk("fl2_full", full_out, 1);
        chk("fl2_start", start_out, 0);
        chk("fl2_count", count_out, 0);
        tick;
        #1;
        chk("postfl_start", start_out, 1);
        chk("postfl_full", full_out, 0);
        chk("postfl_count", count_out, 0);
        chk("postfl_err", overflow_err_out, 1);

        grant_in        = 1'b1;
        clause_in       = 33'h1_2345_6789;
        clause_ready_in = 1'b1;
        #1;
`ifdef CLAUSE_RX_BYPASS_EN
        chk("byp_valid", clause_valid_out, 1);
        chk("byp_clause", clause_out, 33'h1_2345_6789);
`else
        chk("nobyp_valid", clause_valid_out, 0);
`endif
        tick;
        grant_in        = 1'b0;
        clause_ready_in = 1'b0;
        #1;
`ifdef CLAUSE_RX_BYPASS_EN
        chk("byp_count", count_out, 0);
        chk("byp_valid_after", clause_valid_out, 0);
`else
        chk("nobyp_count", count_out, 1);
        chk("nobyp_valid_after", clause_valid_out, 1);
        chk("nobyp_clause", clause_out, 33'h1_2345_6789);
`endif
        clause_ready_in = 1'b1;
        tick;
        clause_ready_in = 1'b0;
        #1;
        chk("lat_drain_count", count_out, 0);

        grant_in  = 1'b1;
        clause_in = 33'h300;
        tick;
        tick;
        grant_in = 1'b0;
        #1;
        chk("mid_count", count_out, 2);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        #1;
        chk("mid_rst_count", count_out, 0);
        chk("mid_rst_valid", clause_valid_out, 0);
        chk("mid_rst_full", full_out, 1);
        chk("mid_rst_start", start_out, 0);
        chk("mid_rst_err", overflow_err_out, 0);
        tick;
        #1;
        chk("mid_run_start", start_out, 1);
        chk("mid_run_count", count_out, 0);
        chk("mid_run_valid", clause_valid_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clause_rx_queue.md
CLAUSE_RX_QUEUE -- requirements
Module: clause_rx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries; power of two, at least 4.
REQ-002 SHALL have parameter CLA_LENGTH, default 3, literals per clause.
REQ-003 SHALL have parameter VARIABLE_LENGTH, default 11, bits per literal; clause width W = CLA_LENGTH*VARIABLE_LENGTH (33).
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset; 0 sampled on a clock edge resets the block.
REQ-006 SHALL have port grant_in, input, 1, arbiter grant for this engine; clause_in is valid this cycle.
REQ-007 SHALL have port clause_in, input, W, the granted clause.
REQ-008 SHALL have port flush_in, input, 1, engine restart request; drop all queued clauses.
REQ-009 SHALL have port clause_ready_in, input, 1, engine consumes clause_out this cycle.
REQ-010 SHALL have port full_out, output, 1, back-pressure to the arbiter's per-engine full input.
REQ-011 SHALL have port start_out, output, 1, engine ready to receive; drives the arbiter's per-engine start input.
REQ-012 SHALL have port clause_out, output, W, head clause.
REQ-013 SHALL have port clause_valid_out, output, 1, clause_out is valid.
REQ-014 SHALL have port count_out, output, clog2(DEPTH)+1, current occupancy.
REQ-015 SHALL have port overflow_err_out, output, 1, sticky error: grant received while no entry was free.

Function
REQ-016 SHALL implement states INIT, RUN, FLUSH; INIT lasts exactly one cycle after reset, then RUN.
REQ-017 SHALL, in INIT and FLUSH: full_out=1, start_out=0, clause_valid_out=0, grants dropped without error.
REQ-018 SHALL, in RUN: start_out=1; full_out=1 combinationally when count >= DEPTH-1.
  - This absorbs the arbiter's one-cycle-registered view of full.
REQ-019 SHALL, in RUN, write clause_in at the tail when grant_in=1 and an entry is free, or is freed by a same-cycle pop.
REQ-020 SHALL pop the head when clause_valid_out=1 and clause_ready_in=1; clause_ready_in with empty queue has no effect.
REQ-021 SHALL, on simultaneous push and pop, leave count unchanged; this includes count==DEPTH.
REQ-022 SHALL, on grant with count==DEPTH and no pop: drop the clause, leave count unchanged, set overflow_err_out from the next cycle.
REQ-023 SHALL wrap read and write pointers modulo DEPTH; FIFO order preserved.
REQ-024 SHALL, when flush_in=1 in RUN: enter FLUSH next cycle with count, pointers and outputs cleared; a same-cycle grant or pop is discarded.
REQ-025 SHALL stay in FLUSH exactly 2 cycles, then return to RUN; flush_in asserted during FLUSH restarts the 2-cycle count.
REQ-026 SHALL have 1-cycle grant-to-clause_valid_out latency when empty, except as in REQ-030.

Reset
REQ-027 SHALL, on reset, set state=INIT, pointers=0, count_out=0, full_out=1, start_out=0, clause_valid_out=0, clause_out=0, overflow_err_out=0.
REQ-028 SHALL, on reset asserted mid-operation, discard queue contents; only reset clears overflow_err_out.

Configuration
REQ-029 SHALL use macro CLAUSE_RX_BYPASS_EN to compile in empty-queue bypass.
REQ-030 SHALL, with CLAUSE_RX_BYPASS_EN in RUN with count==0 and grant_in=1: drive clause_valid_out=1 and clause_out=clause_in the same cycle; if clause_ready_in=1, not store the clause.
REQ-031 SHALL, without CLAUSE_RX_BYPASS_EN, drive clause_out from storage only.

Structure
REQ-032 SHALL take LIT_IDX_MAX, CLA_LENGTH, VARIABLE_LENGTH, NUM_ENGINE, typedef clause_t and the state enum from shared package clause_pkg.
REQ-033 SHALL place the storage array and pointer logic in sub-module clause_rx_storage; FSM, full and error logic live in clause_rx_queue.

Verification
REQ-034 SHALL cover: reset release -> INIT 1 cycle with full_out=1, then RUN with start_out=1, full_out=0, count_out=0.
REQ-035 SHALL cover: DEPTH=8, grants every cycle, clause_ready_in=0 -> full_out=1 at count 7; arbiter model's lagged grant fills to 8; no overflow; FIFO order on drain.
REQ-036 SHALL cover: count 8, grant with clause_ready_in=1 -> count stays 8, new clause at tail, overflow_err_out=0.
REQ-037 SHALL cover: count 8, forced grant with clause_ready_in=0 -> clause dropped, overflow_err_out=1 next cycle and held.
REQ-038 SHALL cover: count 5, flush_in=1 with grant -> next cycle count 0, full_out=1 for 2 cycles, then RUN with start_out=1.
REQ-039 SHALL cover: bypass enabled, empty, grant of 0x1_2345_6789 with clause_ready_in=1 -> clause_valid_out=1 same cycle, count stays 0; disabled -> valid one cycle later.
